// File: rtl/dcsk_chip_mapper.sv
// rtl/dcsk_chip_mapper.sv - DCSK chip mapper: chaos reference half plus replayed information half
//
// Purpose:
//   Sits directly behind the TX chip counter. During the reference half of a
//   bit it pops chaos samples, forwards them and stores them in a small
//   reference buffer. During the information half it replays that buffer,
//   unchanged for a 1 bit or negated with saturation for a 0 bit.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_spreading_factor    0=SF2, 1=SF4, 2=SF8, 3=SF16 (half-bit length 2<<sf)
//   i_sending             chip counter busy; a chip is produced each such cycle
//   i_chip_index          chip index within the current bit
//   i_msb                 0 = reference half, 1 = information half
//   i_load_bit            last chip of the current bit (informational only)
//   i_data_bit            data bit, valid at chip index 0
//   o_bit_consumed        1-cycle pulse after i_data_bit was latched
//   i_chaos_data/valid    head of the chaos FIFO and its non-empty flag
//   o_chaos_rd            combinational pop strobe
//   o_chip/o_chip_valid   registered output chip stream
//   o_underflow           sticky: FIFO empty when a reference sample was needed
//   o_sf_err              sticky: spreading factor changed in the middle of a bit
//   i_clr_err             clears both sticky flags (wins over a same-cycle set)

module dcsk_chip_mapper #(
  parameter int CHIP_W   = 8,
  parameter int MAX_HALF = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_spreading_factor,
  input  logic              i_sending,
  input  logic [4:0]        i_chip_index,
  input  logic              i_msb,
  input  logic              i_load_bit,
  input  logic              i_data_bit,
  output logic              o_bit_consumed,
  input  logic [CHIP_W-1:0] i_chaos_data,
  input  logic              i_chaos_valid,
  output logic              o_chaos_rd,
  output logic [CHIP_W-1:0] o_chip,
  output logic              o_chip_valid,
  output logic              o_underflow,
  output logic              o_sf_err,
  input  logic              i_clr_err
);

  localparam int AW = $clog2(MAX_HALF);
  localparam logic [CHIP_W-1:0] MOST_NEG = {1'b1, {(CHIP_W-1){1'b0}}};
  localparam logic [CHIP_W-1:0] MOST_POS = ~MOST_NEG;

  logic [CHIP_W-1:0] r_ref [MAX_HALF];
  logic              r_bit;
  logic [1:0]        r_sf;

  logic [4:0]        w_half_len;
  logic [4:0]        w_half_mask;
  logic [AW-1:0]     w_lo;
  logic              w_start;
  logic              w_bit;
  logic              w_ref_phase;
  logic [CHIP_W-1:0] w_sample;
  logic [CHIP_W-1:0] w_ref_rd;
  logic [CHIP_W-1:0] w_neg;
  logic [CHIP_W-1:0] w_chip_next;
  logic              w_sf_mismatch;
  logic              w_unused_load_bit;

  // The chip counter wraps the index itself; i_load_bit carries no extra state here.
  assign w_unused_load_bit = i_load_bit;

  // Datapath always follows the live SF so addressing matches the chip counter.
  assign w_half_len  = 5'd2 << i_spreading_factor;
  assign w_half_mask = w_half_len - 5'd1;
  assign w_lo        = AW'(i_chip_index & w_half_mask);

  assign w_start     = i_sending && (i_chip_index == 5'd0);
  // Chip 0 sees the live data bit, before r_bit has been updated.
  assign w_bit       = w_start ? i_data_bit : r_bit;
  assign w_ref_phase = i_sending && !i_msb;

  // An empty FIFO contributes a zero chip, both now and in its replay.
  assign w_sample    = i_chaos_valid ? i_chaos_data : '0;
  assign w_ref_rd    = r_ref[w_lo];
  // Negating the most negative value would wrap to itself; clamp it instead.
  assign w_neg       = (w_ref_rd == MOST_NEG) ? MOST_POS : -w_ref_rd;
  assign w_chip_next = w_ref_phase ? w_sample : (w_bit ? w_ref_rd : w_neg);

  assign w_sf_mismatch = i_sending && (i_chip_index != 5'd0) &&
                         (i_spreading_factor != r_sf);

  // No pop during a reset cycle so the FIFO is not drained by an aborted bit.
  assign o_chaos_rd = w_ref_phase && i_chaos_valid && !i_rst;

  // Reference buffer contents are don't-care after reset, so it has no reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_ref_phase) begin
      r_ref[w_lo] <= w_sample;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit          <= 1'b0;
      r_sf           <= 2'd0;
      o_bit_consumed <= 1'b0;
      o_chip         <= '0;
      o_chip_valid   <= 1'b0;
      o_underflow    <= 1'b0;
      o_sf_err       <= 1'b0;
    end else begin
      o_chip_valid   <= i_sending;
      o_chip         <= i_sending ? w_chip_next : '0;
      o_bit_consumed <= w_start;

      if (w_start) begin
        r_bit <= i_data_bit;
        r_sf  <= i_spreading_factor;
      end

      if (i_clr_err) begin
        o_underflow <= 1'b0;
      end else if (w_ref_phase && !i_chaos_valid) begin
        o_underflow <= 1'b1;
      end

      if (i_clr_err) begin
        o_sf_err <= 1'b0;
      end else if (w_sf_mismatch) begin
        o_sf_err <= 1'b1;
      end
    end
  end

endmodule
